// File: rtl/div_period_monitor_if.sv
// Bus bundle between the divided-clock period monitor and whatever drives or observes it.
// The master side supplies the control and the clock under test; the slave side is the monitor.
interface div_period_monitor_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] n;
    logic             div_in;
    logic [WIDTH:0]   period;
    logic [WIDTH:0]   high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output enable, clear, n, div_in,
        input  period, high_time, meas_valid, locked, err, err_cnt
    );

    modport slave (
        input  enable, clear, n, div_in,
        output period, high_time, meas_valid, locked, err, err_cnt
    );
endinterface

// File: rtl/div_period_monitor.sv
// Measures period and high time of a synchronously generated divided clock against the expected
// even divide factor, reporting lock, a sticky error flag and a saturating error count.
//
// state   | meaning
// IDLE    | disabled or divide factor not checkable; counters held at zero
// SYNC    | waiting for a rising edge to align the measurement window
// MEASURE | checking each period, fewer than LOCK_COUNT consecutive matches
// LOCKED  | LOCK_COUNT or more consecutive matching periods
module div_period_monitor #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    div_period_monitor_if.slave  mon_if
);
    localparam int CW = WIDTH + 1;
    localparam int MW = 4;

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             div_q;
    logic [WIDTH-1:0] n_q, n_d;
    logic [CW-1:0]    pcnt_q, pcnt_d;
    logic [CW-1:0]    hcnt_q, hcnt_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CW-1:0]    period_q, period_d;
    logic [CW-1:0]    high_q, high_d;
    logic             meas_q, meas_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic          rise, n_ok, n_chg, evaluate, meas, hit, stall, err_evt, lock_hit;
    logic [CW-1:0] exp_p, exp_h, stall_lim;
    logic [MW-1:0] match_inc;

    assign rise      = mon_if.div_in & ~div_q;
    assign n_ok      = (mon_if.n >= WIDTH'(2)) && !mon_if.n[0];
    assign n_chg     = (state_q != IDLE) && (mon_if.n != n_q);
    assign evaluate  = mon_if.enable && !n_chg && ((state_q == MEASURE) || (state_q == LOCKED));
    assign exp_p     = {1'b0, n_q};
    assign exp_h     = {2'b00, n_q[WIDTH-1:1]};
    assign stall_lim = {n_q, 1'b0};
    assign meas      = evaluate && rise;
    assign hit       = (pcnt_q == exp_p) && (hcnt_q == exp_h);
    // A stall only fires from MEASURE/LOCKED and moves to SYNC, so it cannot repeat until a rise.
    assign stall     = evaluate && !rise && (pcnt_q > stall_lim);
    assign err_evt   = (meas && !hit) || stall;
    assign match_inc = (match_q == MW'(LOCK_COUNT)) ? match_q : match_q + 1'b1;
    assign lock_hit  = (match_inc == MW'(LOCK_COUNT));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            div_q     <= 1'b0;
            n_q       <= '0;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            match_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            meas_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= mon_if.div_in;
            n_q       <= n_d;
            pcnt_q    <= pcnt_d;
            hcnt_q    <= hcnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            high_q    <= high_d;
            meas_q    <= meas_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mon_if.enable) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (n_ok) state_d = SYNC;
        end else if (n_chg) begin
            state_d = n_ok ? SYNC : IDLE;
        end else begin
            case (state_q)
                SYNC:            if (rise) state_d = MEASURE;
                MEASURE, LOCKED: begin
                    if (meas)       state_d = (hit && lock_hit) ? LOCKED : MEASURE;
                    else if (stall) state_d = SYNC;
                end
                default:         state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        n_d       = (state_q == IDLE || n_chg) ? mon_if.n : n_q;
        pcnt_d    = pcnt_q;
        hcnt_d    = hcnt_q;
        match_d   = match_q;
        period_d  = period_q;
        high_d    = high_q;
        meas_d    = meas;
        locked_d  = (state_d == LOCKED);
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        if (state_q == IDLE) begin
            pcnt_d = '0;
            hcnt_d = '0;
        end else if (rise) begin
            pcnt_d = CW'(1);
            hcnt_d = CW'(1);
        end else begin
            if (!(&pcnt_q))                    pcnt_d = pcnt_q + 1'b1;
            if (mon_if.div_in && !(&hcnt_q))   hcnt_d = hcnt_q + 1'b1;
        end

        if (meas && hit)                               match_d = match_inc;
        else if (meas || state_d == IDLE || state_d == SYNC) match_d = '0;

        if (meas) begin
            period_d = pcnt_q;
            high_d   = hcnt_q;
        end

        // An error event in the same cycle as clear restarts the count at one.
        if (err_evt) begin
            err_d     = 1'b1;
            err_cnt_d = mon_if.clear ? ERR_W'(1) : ((&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1);
        end else if (mon_if.clear) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
    end

    assign mon_if.period     = period_q;
    assign mon_if.high_time  = high_q;
    assign mon_if.meas_valid = meas_q;
    assign mon_if.locked     = locked_q;
    assign mon_if.err        = err_q;
    assign mon_if.err_cnt    = err_cnt_q;
endmodule

// File: doc/div_period_monitor.md
# div_period_monitor

Downstream checker for the even clock divider. Samples the divided output in the fast `clk` domain and measures its period and high time in fast-clock cycles. Compares each measurement against the programmed divide factor `N` and reports lock status, a sticky error flag and a saturating error count. Used on-chip for self-check and by the bench as a scoreboard.

## Interface
- `WIDTH`, 8, width of `N`; internal counters and measurement outputs are `WIDTH+1` bits
- `LOCK_COUNT`, 3, consecutive matching periods required to assert `locked` (1..15)
- `ERR_W`, 8, width of `err_cnt`

- `clk`  in  1  fast clock; same clock that drives the divider
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  monitor enable; low forces IDLE
- `clear`  in  1  synchronous clear of `err` and `err_cnt` only
- `N`  in  WIDTH  expected divide factor; the same value the divider receives
- `div_in`  in  1  divided clock under test, generated synchronously from `clk`
- `period`  out  WIDTH+1  last measured period in `clk` cycles
- `high_time`  out  WIDTH+1  last measured high time in `clk` cycles
- `meas_valid`  out  1  one-cycle pulse when `period`/`high_time` update
- `locked`  out  1  `LOCK_COUNT` consecutive periods matched
- `err`  out  1  sticky mismatch or stall flag
- `err_cnt`  out  ERR_W  saturating count of error events

## Operation
- Edge detect: `div_q` <= `div_in`; `rise` = `div_in & ~div_q`.
- Check rules: `N` is checkable when `N >= 2` and `N[0] == 0`. Expected period = `N`. Expected high time = `N/2`.
- `pcnt`: loads 1 on `rise`, otherwise increments and saturates at all-ones.
- `hcnt`: loads 1 on `rise`, otherwise increments while `div_in == 1`.
- `N_q` holds `N` as captured on entry to SYNC.
- IDLE: entered on reset or `enable == 0`. Counters cleared, `locked = 0`. If `enable` and `N` is checkable, go to SYNC. If `N` is not checkable, stay in IDLE with no checking and no errors.
- SYNC: wait for the first `rise` without measuring. On `rise`, go to MEASURE.
- MEASURE / LOCKED: on each `rise`, latch `period <= pcnt` and `high_time <= hcnt`, and pulse `meas_valid`.
  - Match (`pcnt == N_q` and `hcnt == N_q/2`): increment `match_cnt`. When it reaches `LOCK_COUNT`, go to LOCKED and set `locked = 1`.
  - Mismatch: `err = 1`, `err_cnt` += 1 (saturating), `match_cnt = 0`, `locked = 0`, state = MEASURE.
- Stall: in MEASURE or LOCKED, if `pcnt > 2*N_q` without a `rise`, raise an error event (same effects as a mismatch) and go to SYNC. Only one event per stall; re-arm on the next `rise`.
- `N` change: if `N != N_q` while not in IDLE, go to SYNC (or IDLE if the new `N` is not checkable). Clear `locked` and `match_cnt`. No error event. Recapture `N_q`.
- `enable` falling: go to IDLE on the next edge. `err` and `err_cnt` are held.
- `clear`: zeros `err` and `err_cnt`. If an error event occurs in the same cycle, the error event wins: `err = 1`, `err_cnt = 1`.

## Timing
- All outputs are registered.
- Reset values: `period = 0`, `high_time = 0`, `meas_valid = 0`, `locked = 0`, `err = 0`, `err_cnt = 0`, state = IDLE.
- Latency: `meas_valid`, `period`, `high_time`, `locked` and `err` update on the clock edge after the cycle in which `rise` is seen.
- First measurement occurs at the second `rise` after entering SYNC.
- `locked` rises after `LOCK_COUNT` measurements, i.e. `LOCK_COUNT+1` rising edges after SYNC.
- Stall error registers on the edge after `pcnt` first exceeds `2*N_q`.
- `reset` overrides all other inputs.

## Test plan
- Reset, then `enable = 1`, `N = 4`, ideal `div_in` 2 high / 2 low → `meas_valid` every 4 cycles with `period = 4`, `high_time = 2`. `locked = 1` after the 3rd measurement. `err = 0`.
- Locked at `N = 4`, then one period stretched to 6 (3 high / 3 low) → `period = 6`, `err = 1`, `err_cnt = 1`, `locked = 0`. Relock after 3 good periods with `err` still 1.
- Hold `div_in` high for 12 cycles at `N = 4` → single stall error (`err_cnt` +1), state SYNC. Resume toggling → relock. `err_cnt` does not increment again.
- Change `N` from 4 to 6 mid-run with `div_in` switching to 3/3 → `locked` drops, no error, `locked = 1` again after 4 rising edges at period 6.
- `N = 5` or `N = 0` with arbitrary `div_in` → no `meas_valid`, `locked = 0`, `err = 0`. `enable = 0` mid-lock → `locked = 0` next cycle, `err_cnt` retained.
- `clear` asserted in the same cycle as a mismatch → `err = 1`, `err_cnt = 1`. Drive 300 mismatches with `ERR_W = 8` → `err_cnt` saturates at 255. Assert `reset` mid-measurement → all outputs return to reset values on the next edge.
